// File: rtl/i2c_pkg.sv
// Shared I2C front-end definitions: bit-index sizing, idle level and the
// event bundle handed to the downstream start/stop FSM.
package i2c_pkg;

    localparam int         I2C_BIT_IDX_W  = 4;
    localparam logic [3:0] I2C_ACK_IDX    = 4'd8;
    localparam logic       I2C_IDLE_LEVEL = 1'b1;

    typedef struct packed {
        logic start;
        logic stop;
        logic rise;
        logic fall;
    } i2c_event_t;

    // Frame position after the current bit: data 0..7, ACK at 8, then wrap.
    function automatic logic [I2C_BIT_IDX_W-1:0] next_bit_idx(input logic [I2C_BIT_IDX_W-1:0] idx);
        return (idx == I2C_ACK_IDX) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: SYNC_STAGES-deep synchroniser followed by a counter filter
// that only follows the line after FILTER_LEN consecutive differing cycles.
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic line_raw,
    output logic line_f
);

    localparam logic [3:0] CNT_LAST = 4'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [3:0]             cnt;
    logic                   synced;

    assign synced = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= {SYNC_STAGES{I2C_IDLE_LEVEL}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], line_raw};
        end
    end

    // Reaching CNT_LAST here means this is the FILTER_LEN-th differing cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            line_f <= I2C_IDLE_LEVEL;
        end else if (synced == line_f) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            line_f <= synced;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// I2C bus front end: filtered SCL/SDA plus registered edge, START/STOP and
// per-bit events for the slave start/stop FSM.
module i2c_bus_conditioner
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_raw,
    input  logic       sda_raw,
    output logic       scl_f,
    output logic       sda_f,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       bit_valid,
    output logic       bit_data,
    output logic [3:0] bit_idx,
    output logic       byte_end
);

    logic                     scl_prev;
    logic                     sda_prev;
    logic [I2C_BIT_IDX_W-1:0] bit_cnt;
    i2c_event_t               ev_c;
    i2c_event_t               ev_q;

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_scl_filter (
        .clk      (clk),
        .reset    (reset),
        .line_raw (scl_raw),
        .line_f   (scl_f)
    );

    i2c_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sda_filter (
        .clk      (clk),
        .reset    (reset),
        .line_raw (sda_raw),
        .line_f   (sda_f)
    );

    // START/STOP need SCL high on both sides, so an SDA change coincident
    // with an SCL edge only ever shows up as the SCL edge.
    always_comb begin
        ev_c       = '0;
        ev_c.rise  = !scl_prev && scl_f;
        ev_c.fall  = scl_prev && !scl_f;
        ev_c.start = scl_prev && scl_f && sda_prev && !sda_f;
        ev_c.stop  = scl_prev && scl_f && !sda_prev && sda_f;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_prev  <= I2C_IDLE_LEVEL;
            sda_prev  <= I2C_IDLE_LEVEL;
            ev_q      <= '0;
            bus_busy  <= 1'b0;
            bit_cnt   <= '0;
            bit_valid <= 1'b0;
            bit_data  <= 1'b0;
            bit_idx   <= '0;
            byte_end  <= 1'b0;
        end else begin
            scl_prev  <= scl_f;
            sda_prev  <= sda_f;
            ev_q      <= ev_c;
            bit_valid <= 1'b0;
            byte_end  <= 1'b0;
            if (ev_c.start) begin
                bus_busy <= 1'b1;
                bit_cnt  <= '0;
            end else if (ev_c.stop) begin
                bus_busy <= 1'b0;
                bit_cnt  <= '0;
            end else if (ev_c.rise && bus_busy) begin
                bit_valid <= 1'b1;
                bit_data  <= sda_f;
                bit_idx   <= bit_cnt;
                byte_end  <= (bit_cnt == I2C_ACK_IDX);
                bit_cnt   <= next_bit_idx(bit_cnt);
            end
        end
    end

    assign scl_rise  = ev_q.rise;
    assign scl_fall  = ev_q.fall;
    assign start_det = ev_q.start;
    assign stop_det  = ev_q.stop;

endmodule
